lap_sched: RTL

Sequencing controller for the stopwatch datapath. It turns the edge-detected start/stop/split/recall pulses into the counter enable and clear. It stores up to DEPTH split (lap) times in a circular buffer and schedules which value drives the 8-digit display: live time, a held split, or a recalled lap. It sits between the edge detectors and the elapsed-time counter / `dspl_drv_NexysA7` display driver.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/lap_buffer.sv | 40 ++++
 rtl/lap_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath.
//   sched_state_t : lap scheduler state encoding
//   BCD_W         : width of an 8-digit BCD time value
//   DIG_*         : digit positions inside a BCD value, counted from the
//                   least significant nibble (u_cs) upward
package stopwatch_pkg;

  localparam int BCD_W = 32;
  localparam int DIG_W = 4;

  localparam int DIG_U_CS = 0;
  localparam int DIG_D_CS = 1;
  localparam int DIG_U_S  = 2;
  localparam int DIG_D_S  = 3;
  localparam int DIG_U_M  = 4;
  localparam int DIG_D_M  = 5;
  localparam int DIG_U_H  = 6;
  localparam int DIG_D_H  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_STOPPED,
    S_RECALL
  } sched_state_t;

endpackage

// File: rtl/lap_buffer.sv
// Lap time register file: DEPTH slots of BCD_W bits.
//   clock, reset : system clock, asynchronous active-low reset (clears all slots)
//   wr_en        : write wr_data into slot wr_addr on the rising edge
//   wr_addr      : write slot index
//   wr_data      : value to store
//   rd_addr      : read slot index
//   rd_data      : combinational contents of slot rd_addr
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [BCD_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [BCD_W-1:0]         rd_data
);

  logic [BCD_W-1:0] mem_q [DEPTH];
  logic [BCD_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lap_sched.sv
// Stopwatch sequencing controller.
// Turns start/stop/split/recall pulses into counter enable/clear, keeps the
// most recent DEPTH split times in a circular buffer and selects what the
// display shows: live time, a freshly captured split (for HOLD_CS ticks), or
// a recalled lap.
//   clock, reset : system clock, asynchronous active-low reset
//   tick_cs      : one-cycle centisecond strobe
//   start_p, stop_p, split_p, recall_p : one-cycle control pulses
//   live_bcd     : live elapsed time (8 BCD digits)
//   count_en     : elapsed-time counter enable
//   clear_cnt    : one-cycle counter clear
//   disp_bcd     : value for the display driver
//   lap_num      : 1-based lap shown (counted from the oldest), 0 for live
//   lap_count    : number of valid laps stored, saturates at DEPTH
//   full         : lap_count == DEPTH
module lap_sched
  import stopwatch_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int HOLD_CS = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_cs,
  input  logic             start_p,
  input  logic             stop_p,
  input  logic             split_p,
  input  logic             recall_p,
  input  logic [BCD_W-1:0] live_bcd,
  output logic             count_en,
  output logic             clear_cnt,
  output logic [BCD_W-1:0] disp_bcd,
  output logic [3:0]       lap_num,
  output logic [3:0]       lap_count,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int HC_W  = $clog2(HOLD_CS + 1);
  localparam logic [3:0]      DEPTH_L   = 4'(DEPTH);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CS - 1);

  sched_state_t     state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_idx_q, rd_idx_d;
  logic [3:0]       lap_count_q, lap_count_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             clear_q, clear_d;

  logic             lap_wr;
  logic [PTR_W-1:0] newest, oldest, rd_addr, rd_pos;
  logic [BCD_W-1:0] rd_data;

  // Only the highest-priority pulse of a cycle takes effect.
  logic stop_w, start_w, split_w, recall_w;
  assign stop_w   = stop_p;
  assign start_w  = start_p & ~stop_p;
  assign split_w  = split_p & ~stop_p & ~start_p;
  assign recall_w = recall_p & ~stop_p & ~start_p & ~split_p;

  assign full   = (lap_count_q == DEPTH_L);
  assign newest = wr_ptr_q - PTR_W'(1);
  // Until the buffer first fills, the oldest lap sits in slot 0; afterwards
  // the next slot to be overwritten is the oldest.
  assign oldest = full ? wr_ptr_q : '0;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_idx_d    = rd_idx_q;
    lap_count_d = lap_count_q;
    hold_cnt_d  = hold_cnt_q;
    clear_d     = 1'b0;
    lap_wr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_w) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop_w) begin
          state_d = S_STOPPED;
        end else if (split_w) begin
          lap_wr     = 1'b1;
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (stop_w) begin
          state_d = S_STOPPED;
        end else if (split_w) begin
          lap_wr     = 1'b1;
          hold_cnt_d = '0;
        end else if (tick_cs) begin
          if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
          else hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      S_STOPPED: begin
        if (start_w) begin
          state_d = S_RUN;
        end else if (split_w) begin
          state_d     = S_IDLE;
          clear_d     = 1'b1;
          lap_count_d = '0;
          wr_ptr_d    = '0;
        end else if (recall_w && (lap_count_q != 4'd0)) begin
          state_d  = S_RECALL;
          rd_idx_d = newest;
        end
      end
      S_RECALL: begin
        if (stop_w) begin
          state_d = S_STOPPED;
        end else if (start_w) begin
          state_d = S_RUN;
        end else if (recall_w) begin
          rd_idx_d = (rd_idx_q == oldest) ? newest : rd_idx_q - PTR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (lap_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!full) lap_count_d = lap_count_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_idx_q    <= '0;
      lap_count_q <= '0;
      hold_cnt_q  <= '0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_idx_q    <= rd_idx_d;
      lap_count_q <= lap_count_d;
      hold_cnt_q  <= hold_cnt_d;
      clear_q     <= clear_d;
    end
  end

  assign rd_addr = (state_q == S_RECALL) ? rd_idx_q : newest;

  lap_buffer #(.DEPTH(DEPTH)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (lap_wr),
    .wr_addr (wr_ptr_q),
    .wr_data (live_bcd),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Position of the recalled slot relative to the oldest stored lap.
  assign rd_pos = rd_idx_q - oldest;

  always_comb begin
    disp_bcd = live_bcd;
    lap_num  = 4'd0;
    case (state_q)
      S_HOLD: begin
        disp_bcd = rd_data;
        lap_num  = lap_count_q;
      end
      S_RECALL: begin
        disp_bcd = rd_data;
        lap_num  = 4'(rd_pos) + 4'd1;
      end
      default: ;
    endcase
  end

  assign count_en  = (state_q == S_RUN) || (state_q == S_HOLD);
  assign clear_cnt = clear_q;
  assign lap_count = lap_count_q;

endmodule
